ps2_key_decoder: RTL and testbench



---
 rtl/ps2_pkg.sv | 32 +++
 rtl/ps2_rx_frame.sv | 139 +++++++++++++
 rtl/ps2_key_decoder.sv | 75 +++++++
 tb/tb_ps2_key_decoder.sv | 158 +++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// Shared PS/2 scancode constants and the frame receiver state encoding.
package ps2_pkg;

    localparam logic [7:0] SC_EXT    = 8'hE0;
    localparam logic [7:0] SC_BRK    = 8'hF0;

    localparam logic [7:0] SC_LEFT   = 8'h6B;
    localparam logic [7:0] SC_RIGHT  = 8'h74;
    localparam logic [7:0] SC_UP     = 8'h75;
    localparam logic [7:0] SC_DOWN   = 8'h72;

    // Keyboard housekeeping bytes that never represent a key press
    localparam logic [7:0] SC_BAT    = 8'hAA;
    localparam logic [7:0] SC_ACK    = 8'hFA;
    localparam logic [7:0] SC_ECHO   = 8'hEE;
    localparam logic [7:0] SC_RESEND = 8'hFE;
    localparam logic [7:0] SC_ERR0   = 8'h00;
    localparam logic [7:0] SC_ERR1   = 8'hFF;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } frame_state_t;

    function automatic logic is_ignored(input logic [7:0] b);
        return (b == SC_BAT) || (b == SC_ACK) || (b == SC_ECHO) ||
               (b == SC_RESEND) || (b == SC_ERR0) || (b == SC_ERR1);
    endfunction

endpackage

// File: rtl/ps2_rx_frame.sv
// PS/2 device-to-host frame receiver: synchronizers, clock deglitch filter,
// 11-bit frame FSM with parity/stop checking and an inter-bit timeout.
module ps2_rx_frame
    import ps2_pkg::*;
#(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 25000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] rx_byte,
    output logic       byte_valid,
    output logic       rx_err
);

    localparam int FW = $clog2(FILTER_LEN + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    logic [1:0]   clk_sync, data_sync;
    logic         filt_clk, filt_prev;
    logic [FW-1:0] filt_cnt;
    logic         strobe, bit_in;

    frame_state_t  state, state_n;
    logic [2:0]    bitcnt, bitcnt_n;
    logic [7:0]    shreg, shreg_n;
    logic          par, par_n;
    logic [TW-1:0] tocnt, tocnt_n;
    logic          bv_n, err_n;

    // Two-flop synchronizers; idle PS/2 lines are high, so reset to 1
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clk_sync  <= 2'b11;
            data_sync <= 2'b11;
        end else begin
            clk_sync  <= {clk_sync[0], ps2_clk};
            data_sync <= {data_sync[0], ps2_data};
        end
    end

    // Filtered clock follows the synchronized clock only after FILTER_LEN equal samples
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            filt_clk  <= 1'b1;
            filt_prev <= 1'b1;
            filt_cnt  <= '0;
        end else begin
            filt_prev <= filt_clk;
            if (clk_sync[1] != filt_clk) begin
                if (filt_cnt == FW'(FILTER_LEN - 1)) begin
                    filt_clk <= clk_sync[1];
                    filt_cnt <= '0;
                end else begin
                    filt_cnt <= filt_cnt + FW'(1);
                end
            end else begin
                filt_cnt <= '0;
            end
        end
    end

    // Bits are sampled on the falling edge of the filtered clock
    assign strobe  = filt_prev & ~filt_clk;
    assign bit_in  = data_sync[1];
    assign rx_byte = shreg;

    // Frame FSM state and result pulses
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            bitcnt     <= '0;
            shreg      <= '0;
            par        <= 1'b0;
            tocnt      <= '0;
            byte_valid <= 1'b0;
            rx_err     <= 1'b0;
        end else begin
            state      <= state_n;
            bitcnt     <= bitcnt_n;
            shreg      <= shreg_n;
            par        <= par_n;
            tocnt      <= tocnt_n;
            byte_valid <= bv_n;
            rx_err     <= err_n;
        end
    end

    // Frame FSM next-state; a strobe always beats the timeout terminal count
    always_comb begin
        state_n  = state;
        bitcnt_n = bitcnt;
        shreg_n  = shreg;
        par_n    = par;
        tocnt_n  = '0;
        bv_n     = 1'b0;
        err_n    = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (strobe && !bit_in) begin
                    state_n  = ST_DATA;
                    bitcnt_n = '0;
                end
            end
            ST_DATA: begin
                if (strobe) begin
                    shreg_n  = {bit_in, shreg[7:1]};
                    bitcnt_n = bitcnt + 3'd1;
                    if (bitcnt == 3'd7) state_n = ST_PARITY;
                end
            end
            ST_PARITY: begin
                if (strobe) begin
                    par_n   = bit_in;
                    state_n = ST_STOP;
                end
            end
            ST_STOP: begin
                if (strobe) begin
                    if (bit_in && ^{shreg, par}) bv_n = 1'b1;
                    else                         err_n = 1'b1;
                    state_n = ST_IDLE;
                end
            end
            default: state_n = ST_IDLE;
        endcase
        if (state != ST_IDLE && !strobe) begin
            if (tocnt == TW'(TIMEOUT_CYCLES - 1)) begin
                state_n = ST_IDLE;
                err_n   = 1'b1;
            end else begin
                tocnt_n = tocnt + TW'(1);
            end
        end
    end

endmodule

// File: rtl/ps2_key_decoder.sv
// PS/2 keyboard front end: strips E0/F0 prefixes and strobes each key make.
module ps2_key_decoder
    import ps2_pkg::*;
#(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 25000
) (
    input  logic       iVGA_CLK,
    input  logic       iRST_n,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] key_in,
    output logic       key_en,
    output logic       key_ext,
    output logic       rx_err
);

    logic [7:0] rx_byte;
    logic       byte_valid;
    logic       ext, brk, ext_n, brk_n, upd;

    ps2_rx_frame #(
        .FILTER_LEN     (FILTER_LEN),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_rx (
        .clk        (iVGA_CLK),
        .rst_n      (iRST_n),
        .ps2_clk    (ps2_clk),
        .ps2_data   (ps2_data),
        .rx_byte    (rx_byte),
        .byte_valid (byte_valid),
        .rx_err     (rx_err)
    );

    // Prefix flags and the registered key outputs
    always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
        if (!iRST_n) begin
            ext     <= 1'b0;
            brk     <= 1'b0;
            key_in  <= '0;
            key_en  <= 1'b0;
            key_ext <= 1'b0;
        end else begin
            ext    <= ext_n;
            brk    <= brk_n;
            key_en <= upd;
            if (upd) begin
                key_in  <= rx_byte;
                key_ext <= ext;
            end
        end
    end

    // Scancode decode: prefixes set flags, any other byte consumes them
    always_comb begin
        ext_n = ext;
        brk_n = brk;
        upd   = 1'b0;
        if (rx_err) begin
            ext_n = 1'b0;
            brk_n = 1'b0;
        end else if (byte_valid) begin
            if (rx_byte == SC_EXT) begin
                ext_n = 1'b1;
            end else if (rx_byte == SC_BRK) begin
                brk_n = 1'b1;
            end else begin
                ext_n = 1'b0;
                brk_n = 1'b0;
                upd   = !brk && !is_ignored(rx_byte);
            end
        end
    end

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Directed bench for ps2_key_decoder: drives PS/2 frames, checks decoded keys.
module tb_ps2_key_decoder;

    localparam int HALF = 40;   // PS/2 half period in system clocks
    localparam int TO   = 1000;

    logic       iVGA_CLK = 1'b0;
    logic       iRST_n   = 1'b0;
    logic       ps2_clk  = 1'b1;
    logic       ps2_data = 1'b1;
    logic [7:0] key_in;
    logic       key_en, key_ext, rx_err;

    int tests = 0, fails = 0;
    int cyc = 0, en_cnt = 0, err_cnt = 0, en_cyc = 0, stop_cyc = 0;
    logic [7:0] last_key = 8'h00;
    logic       last_ext = 1'b0, prev_en = 1'b0, dbl_en = 1'b0;

    ps2_key_decoder #(.FILTER_LEN(8), .TIMEOUT_CYCLES(TO)) dut (
        .iVGA_CLK (iVGA_CLK),
        .iRST_n   (iRST_n),
        .ps2_clk  (ps2_clk),
        .ps2_data (ps2_data),
        .key_in   (key_in),
        .key_en   (key_en),
        .key_ext  (key_ext),
        .rx_err   (rx_err)
    );

    always #5 iVGA_CLK = ~iVGA_CLK;

    always @(posedge iVGA_CLK) cyc <= cyc + 1;

    // Output monitor, sampled on the inactive edge
    always @(negedge iVGA_CLK) begin
        if (key_en) begin
            en_cnt   <= en_cnt + 1;
            last_key <= key_in;
            last_ext <= key_ext;
            en_cyc   <= cyc;
        end
        if (rx_err) err_cnt <= err_cnt + 1;
        if (prev_en && key_en) dbl_en <= 1'b1;
        prev_en <= key_en;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Send the first nbits of a frame (start, 8 data LSB first, parity, stop)
    task automatic send(input logic [7:0] b, input bit bad_par, input int nbits);
        logic [10:0] f;
        f = {1'b1, (~^b) ^ bad_par, b, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            @(negedge iVGA_CLK);
            ps2_data = f[i];
            repeat (HALF) @(negedge iVGA_CLK);
            ps2_clk = 1'b0;
            if (i == 10) stop_cyc = cyc;
            repeat (HALF) @(negedge iVGA_CLK);
            ps2_clk = 1'b1;
        end
        ps2_data = 1'b1;
        repeat (2 * HALF) @(negedge iVGA_CLK);
    endtask

    int e0;

    initial begin
        repeat (5) @(negedge iVGA_CLK);
        chk("rst_key_in", key_in, 0);
        chk("rst_key_en", key_en, 0);
        chk("rst_key_ext", key_ext, 0);
        chk("rst_rx_err", rx_err, 0);
        iRST_n = 1'b1;
        repeat (5) @(negedge iVGA_CLK);

        // 3-cycle glitch on an idle line must be filtered out
        ps2_clk = 1'b0;
        repeat (3) @(negedge iVGA_CLK);
        ps2_clk = 1'b1;
        repeat (50) @(negedge iVGA_CLK);
        chk("glitch_en", en_cnt, 0);
        chk("glitch_err", err_cnt, 0);

        // Extended make: left arrow
        send(8'hE0, 0, 11);
        chk("e0_no_en", en_cnt, 0);
        send(8'h6B, 0, 11);
        chk("left_en", en_cnt, 1);
        chk("left_key", last_key, 8'h6B);
        chk("left_ext", last_ext, 1);
        chk("left_lat", en_cyc - stop_cyc, 12);

        // Plain make then extended break of the same code
        send(8'h74, 0, 11);
        chk("right_en", en_cnt, 2);
        chk("right_key", last_key, 8'h74);
        chk("right_ext", last_ext, 0);
        send(8'hE0, 0, 11);
        send(8'hF0, 0, 11);
        send(8'h74, 0, 11);
        chk("brk_no_en", en_cnt, 2);
        chk("brk_key_held", key_in, 8'h74);

        // Parity error then recovery
        send(8'h72, 1, 11);
        chk("par_err", err_cnt, 1);
        chk("par_no_en", en_cnt, 2);
        send(8'h1C, 0, 11);
        chk("a_en", en_cnt, 3);
        chk("a_key", last_key, 8'h1C);
        chk("a_ext", last_ext, 0);

        // Ignored housekeeping byte
        send(8'hAA, 0, 11);
        chk("bat_no_en", en_cnt, 3);

        // Timeout after start + 4 data bits
        send(8'h75, 0, 5);
        repeat (TO + 200) @(negedge iVGA_CLK);
        chk("to_err", err_cnt, 2);
        chk("to_no_en", en_cnt, 3);
        send(8'h75, 0, 11);
        chk("up_en", en_cnt, 4);
        chk("up_key", last_key, 8'h75);

        // Reset in the middle of a frame
        send(8'h6B, 0, 4);
        e0 = en_cnt;
        iRST_n = 1'b0;
        #1;
        chk("mid_rst_key", key_in, 0);
        chk("mid_rst_en", key_en, 0);
        chk("mid_rst_ext", key_ext, 0);
        repeat (5) @(negedge iVGA_CLK);
        iRST_n = 1'b1;
        repeat (200) @(negedge iVGA_CLK);
        chk("post_rst_no_en", en_cnt, e0);
        send(8'hE0, 0, 11);
        send(8'h72, 0, 11);
        chk("down_en", en_cnt, e0 + 1);
        chk("down_key", last_key, 8'h72);
        chk("down_ext", last_ext, 1);
        chk("down_err_none", err_cnt, 2);

        chk("no_double_en", dbl_en, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
